// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants and entry type for the register-file writeback path
package wb_pkg;

    localparam int DATA_W   = 22;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 11;
    localparam int DEPTH    = 4;
    localparam int PTR_W    = $clog2(DEPTH);
    // Wide enough for DEPTH queued writes plus one on the port plus one arriving
    localparam int CNT_W    = $clog2(DEPTH + 2);

    // First non-writable address; r11 is an external read-only input
    localparam logic [ADDR_W-1:0] R_EXT = 4'd11;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of writeback entries
module wb_fifo
    import wb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_entry_t        push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count,
    output wb_entry_t        head
);

    wb_entry_t         mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - merges ALU and load writebacks onto the register-file write port
module regfile_wb_arbiter
    import wb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_wa,
    output logic [DATA_W-1:0]   rf_wd,
    output logic [NUM_REGS-1:0] pend_mask,
    output logic                busy,
    output logic                err_bad_reg
);

    logic              fifo_full;
    logic              fifo_empty;
    logic [PTR_W:0]    fifo_count;
    wb_entry_t         head;
    wb_entry_t         req;
    logic              mem_fire;
    logic              alu_fire;
    logic              any_fire;
    logic              req_ok;
    logic              push;
    logic [CNT_W-1:0]  pend_cnt [NUM_REGS];

    // Loads win; the ALU waits whenever a load is presented
    assign mem_ready = !rst && !fifo_full;
    assign alu_ready = !rst && !fifo_full && !mem_valid;
    assign mem_fire  = mem_valid && mem_ready;
    assign alu_fire  = alu_valid && alu_ready;
    assign any_fire  = mem_fire || alu_fire;

    assign req.rd    = mem_fire ? mem_rd   : alu_rd;
    assign req.data  = mem_fire ? mem_data : alu_data;
    // Out-of-range destinations complete the handshake but are dropped
    assign req_ok    = (req.rd < R_EXT);
    assign push      = any_fire && req_ok;

    assign busy      = (fifo_count != '0) || rf_we;

    wb_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (req),
        .pop       (!fifo_empty),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (head)
    );

    // Drain one entry per cycle onto the registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else if (!fifo_empty) begin
            rf_we <= 1'b1;
            rf_wa <= head.rd;
            rf_wd <= head.data;
        end else begin
            rf_we <= 1'b0;
        end
    end

    // Sticky flag for accepted requests targeting a non-writable register
    always_ff @(posedge clk) begin
        if (rst) begin
            err_bad_reg <= 1'b0;
        end else if (any_fire && !req_ok) begin
            err_bad_reg <= 1'b1;
        end
    end

    // Outstanding-write counters: up on enqueue, down when a port write cycle ends
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rst) begin
                pend_cnt[r] <= '0;
            end else begin
                case ({push && (req.rd == ADDR_W'(r)), rf_we && (rf_wa == ADDR_W'(r))})
                    2'b10:   pend_cnt[r] <= pend_cnt[r] + CNT_W'(1);
                    2'b01:   pend_cnt[r] <= pend_cnt[r] - CNT_W'(1);
                    default: pend_cnt[r] <= pend_cnt[r];
                endcase
            end
        end
    end

    // Decode stalls on any register with a write still in flight
    always_comb begin
        pend_mask = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_mask[r] = (pend_cnt[r] != '0);
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    import wb_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                alu_valid;
    logic                alu_ready;
    logic [ADDR_W-1:0]   alu_rd;
    logic [DATA_W-1:0]   alu_data;
    logic                mem_valid;
    logic                mem_ready;
    logic [ADDR_W-1:0]   mem_rd;
    logic [DATA_W-1:0]   mem_data;
    logic                rf_we;
    logic [ADDR_W-1:0]   rf_wa;
    logic [DATA_W-1:0]   rf_wd;
    logic [NUM_REGS-1:0] pend_mask;
    logic                busy;
    logic                err_bad_reg;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd),
        .pend_mask   (pend_mask),
        .busy        (busy),
        .err_bad_reg (err_bad_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic              av;
        logic [ADDR_W-1:0] ard;
        logic [DATA_W-1:0] ad;
        logic              mv;
        logic [ADDR_W-1:0] mrd;
        logic [DATA_W-1:0] md;
        logic              e_ar;
        logic              e_mr;
        logic              e_err;
    } vec_t;

    int checks = 0;
    int errors = 0;

    wb_entry_t         mq[$];
    wb_entry_t         sb[$];
    logic              m_we;
    logic [ADDR_W-1:0] m_wa;
    logic [DATA_W-1:0] m_wd;
    logic              m_err;
    int                m_pend [NUM_REGS];
    vec_t              tbl[$];

    function automatic vec_t mk(logic r, logic av, logic [3:0] ard, logic [21:0] ad,
                                logic mv, logic [3:0] mrd, logic [21:0] md,
                                logic ear, logic emr, logic eerr);
        vec_t v;
        v.rst = r;  v.av = av; v.ard = ard; v.ad = ad;
        v.mv = mv;  v.mrd = mrd; v.md = md;
        v.e_ar = ear; v.e_mr = emr; v.e_err = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input vec_t v);
        wb_entry_t e;
        logic full, mfire, afire;
        if (v.rst) begin
            mq.delete();
            sb.delete();
            m_we = 1'b0; m_wa = '0; m_wd = '0; m_err = 1'b0;
            for (int r = 0; r < NUM_REGS; r++) m_pend[r] = 0;
            return;
        end
        full  = (mq.size() >= DEPTH);
        mfire = v.mv && !full;
        afire = v.av && !full && !v.mv;
        if (m_we) m_pend[m_wa]--;
        if (mq.size() > 0) begin
            e = mq.pop_front();
            m_we = 1'b1; m_wa = e.rd; m_wd = e.data;
        end else begin
            m_we = 1'b0;
        end
        if (mfire || afire) begin
            e.rd   = mfire ? v.mrd : v.ard;
            e.data = mfire ? v.md  : v.ad;
            if (e.rd < 4'd11) begin
                mq.push_back(e);
                sb.push_back(e);
                m_pend[e.rd]++;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic step(input vec_t v);
        logic [NUM_REGS-1:0] em;
        logic e_mr, e_ar;
        wb_entry_t e;
        @(negedge clk);
        rst = v.rst; alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
        mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.md;
        #1;
        e_mr = !v.rst && (mq.size() < DEPTH);
        e_ar = e_mr && !v.mv;
        for (int r = 0; r < NUM_REGS; r++) em[r] = (m_pend[r] != 0);
        chk("mem_ready", mem_ready, e_mr);
        chk("alu_ready", alu_ready, e_ar);
        chk("tbl_mem_ready", mem_ready, v.e_mr);
        chk("tbl_alu_ready", alu_ready, v.e_ar);
        chk("tbl_err_bad_reg", err_bad_reg, v.e_err);
        chk("rf_we", rf_we, m_we);
        chk("rf_wa", rf_wa, m_wa);
        chk("rf_wd", rf_wd, m_wd);
        chk("pend_mask", pend_mask, em);
        chk("busy", busy, (mq.size() != 0) || m_we);
        chk("err_bad_reg", err_bad_reg, m_err);
        if (rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_write", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_rd", rf_wa, e.rd);
                chk("sb_data", rf_wd, e.data);
            end
        end
        model_edge(v);
    endtask

    initial begin
        rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        repeat (2) @(negedge clk);
        model_edge(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // rst, av, ard, ad, mv, mrd, md, exp alu_ready, exp mem_ready, exp err
        tbl.push_back(mk(1, 0, 0, 0,         0, 0, 0,         0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 22'h12345, 0, 0, 0,         1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 0,         1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 0,         1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 0,         1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 22'h00111, 1, 2, 22'h00222, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 22'h00111, 0, 0, 0,         1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 0,         1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 0,         1, 1, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 1, 4'(4 + i), 22'(22'h3A000 + i * 17), 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 0,         1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 0,         1, 1, 0));
        tbl.push_back(mk(0, 1, 5, 22'h0AAAA, 0, 0, 0,         1, 1, 0));
        tbl.push_back(mk(0, 1, 5, 22'h0BBBB, 0, 0, 0,         1, 1, 0));
        tbl.push_back(mk(0, 1, 5, 22'h0CCCC, 0, 0, 0,         1, 1, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 0, 0, 0,     0, 0, 0,         1, 1, 0));
        tbl.push_back(mk(0, 1, 11, 22'h3FFFF, 0, 0, 0,        1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         1, 15, 22'h1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 0,         1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 22'h00C0C, 0, 0, 0,         1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 0,         1, 1, 1));
        tbl.push_back(mk(0, 1, 10, 22'h10101, 0, 0, 0,        1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,         1, 10, 22'h20202, 0, 1, 1));
        tbl.push_back(mk(0, 1, 2, 22'h30303, 0, 0, 0,         1, 1, 1));
        tbl.push_back(mk(1, 1, 3, 22'h05555, 0, 0, 0,         0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 0,         1, 1, 0));
        tbl.push_back(mk(0, 1, 6, 22'h06666, 1, 7, 22'h07777, 0, 1, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 0,     0, 0, 0,         1, 1, 0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Single write latency: accept, wait one cycle, port write, then idle
        step(mk(0, 1, 9, 22'h2AAAA, 0, 0, 0, 1, 1, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        chk("lat_we_cycle1", rf_we, 1'b0);
        chk("lat_pend9_cycle1", pend_mask, 11'h200);
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        chk("lat_we_cycle2", rf_we, 1'b1);
        chk("lat_wa_cycle2", rf_wa, 4'd9);
        chk("lat_wd_cycle2", rf_wd, 22'h2AAAA);
        chk("lat_pend9_cycle2", pend_mask, 11'h200);
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        chk("lat_we_cycle3", rf_we, 1'b0);
        chk("lat_pend_cycle3", pend_mask, 11'h000);
        chk("lat_busy_cycle3", busy, 1'b0);

        // Reset while a write sits on the port drops everything
        step(mk(0, 1, 8, 22'h18888, 0, 0, 0, 1, 1, 0));
        step(mk(0, 1, 8, 22'h19999, 0, 0, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("rst_we_before", rf_we, 1'b1);
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        chk("rst_we_after", rf_we, 1'b0);
        chk("rst_pend_after", pend_mask, 11'h000);
        chk("rst_busy_after", busy, 1'b0);
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
